// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared constants and types for the machine-mode CSR write path
// Purpose: CSR addresses, csr_out slot indices, the csr_op encoding and the
// mstatus field layout used by csr_write_unit and csr_rmw.
// Ports: none (package).
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  // Slots in the csr_out array
  localparam int IDX_MSCRATCH = 0;
  localparam int IDX_MSTATUS  = 1;
  localparam int IDX_MCAUSE   = 2;
  localparam int IDX_MTVEC    = 3;
  localparam int IDX_MEPC     = 4;

  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_RW  = 2'b01,
    CSR_RS  = 2'b10,
    CSR_RC  = 2'b11
  } csr_op_e;

  // mstatus layout
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [63:0] MSTATUS_RESET = 64'h0000_0000_0000_1800;
  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_0088;

  // Keep only MIE/MPIE from a written value; MPP is hard-wired to M-mode.
  function automatic logic [63:0] mstatus_legalize(logic [63:0] v);
    return (v & MSTATUS_WMASK) | MSTATUS_RESET;
  endfunction

endpackage

// File: rtl/csr_rmw.sv
// rtl/csr_rmw.sv - read-modify-write value computation for CSR instructions
// Purpose: combinational next-value for RW/RS/RC and whether the access writes.
// Ports:
//   old_i       current stored value
//   wdata_i     rs1 value or zero-extended zimm
//   op_i        csr_op encoding
//   next_o      value to store if the write goes ahead
//   write_eff_o 1 when the access is an actual write (RS/RC with 0 is a read)
module csr_rmw
  import csr_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] old_i,
  input  logic [N-1:0] wdata_i,
  input  csr_op_e      op_i,
  output logic [N-1:0] next_o,
  output logic         write_eff_o
);

  always_comb begin
    next_o      = old_i;
    write_eff_o = 1'b0;
    case (op_i)
      CSR_RW: begin
        next_o      = wdata_i;
        write_eff_o = 1'b1;
      end
      CSR_RS: begin
        next_o      = old_i | wdata_i;
        write_eff_o = |wdata_i;
      end
      CSR_RC: begin
        next_o      = old_i & ~wdata_i;
        write_eff_o = |wdata_i;
      end
      default: begin
        next_o      = old_i;
        write_eff_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_write_unit.sv
// rtl/csr_write_unit.sv - M-mode CSR storage with RMW writes, trap entry and MRET
// Purpose: holds mscratch/mstatus/mcause/mtvec/mepc, applies CSR instruction
// writes, trap entry and MRET updates, and flags illegal writes.
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   csr_we, csr_op, addr, wdata   CSR instruction access
//   trap_valid, trap_pc, trap_cause   trap entry request
//   mret_valid            MRET retiring
//   csr_out               storage array read by csr_dec (slots 0..4 live)
//   mtvec_o, mepc_o       trap vector and MRET return target
//   illegal_o             registered pulse: last cycle's write was illegal
module csr_write_unit
  import csr_pkg::*;
#(
  parameter int N     = 64,
  parameter int W_CSR = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      csr_we,
  input  logic [1:0]                csr_op,
  input  logic [11:0]               addr,
  input  logic [N-1:0]              wdata,
  input  logic                      trap_valid,
  input  logic [N-1:0]              trap_pc,
  input  logic [N-1:0]              trap_cause,
  input  logic                      mret_valid,
  output logic [W_CSR-1:0][N-1:0]   csr_out,
  output logic [N-1:0]              mtvec_o,
  output logic [N-1:0]              mepc_o,
  output logic                      illegal_o
);

  logic [N-1:0] mscratch_q, mstatus_q, mcause_q, mtvec_q, mepc_q;
  logic         illegal_q;

  logic [N-1:0] old_val;
  logic [N-1:0] rmw_next;
  logic         write_eff;
  logic         wr_en;

  // Unmapped addresses read as 0; the write is rejected anyway.
  always_comb begin
    old_val = '0;
    case (addr)
      ADDR_MSCRATCH: old_val = mscratch_q;
      ADDR_MSTATUS:  old_val = mstatus_q;
      ADDR_MCAUSE:   old_val = mcause_q;
      ADDR_MTVEC:    old_val = mtvec_q;
      ADDR_MEPC:     old_val = mepc_q;
      default:       old_val = '0;
    endcase
  end

  csr_rmw #(.N(N)) u_rmw (
    .old_i       (old_val),
    .wdata_i     (wdata),
    .op_i        (csr_op_e'(csr_op)),
    .next_o      (rmw_next),
    .write_eff_o (write_eff)
  );

  // Trap and MRET both pre-empt the instruction's write (it does not retire).
  assign wr_en = csr_we & write_eff & ~trap_valid & ~mret_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mscratch_q <= '0;
      mstatus_q  <= N'(MSTATUS_RESET);
      mcause_q   <= '0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      illegal_q  <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (trap_valid) begin
        mepc_q                 <= {trap_pc[N-1:2], 2'b00};
        mcause_q               <= trap_cause;
        mstatus_q[MSTATUS_MPIE] <= mstatus_q[MSTATUS_MIE];
        mstatus_q[MSTATUS_MIE]  <= 1'b0;
      end else if (mret_valid) begin
        mstatus_q[MSTATUS_MIE]  <= mstatus_q[MSTATUS_MPIE];
        mstatus_q[MSTATUS_MPIE] <= 1'b1;
      end else if (wr_en) begin
        case (addr)
          ADDR_MSCRATCH: mscratch_q <= rmw_next;
          ADDR_MSTATUS:  mstatus_q  <= N'(mstatus_legalize(64'(rmw_next)));
          ADDR_MCAUSE:   mcause_q   <= rmw_next;
          ADDR_MTVEC:    mtvec_q    <= {rmw_next[N-1:2], 2'b00};
          ADDR_MEPC:     mepc_q     <= {rmw_next[N-1:2], 2'b00};
          // misa, the read-only ID CSRs and unmapped addresses all land here
          default:       illegal_q  <= 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    csr_out               = '0;
    csr_out[IDX_MSCRATCH] = mscratch_q;
    csr_out[IDX_MSTATUS]  = mstatus_q;
    csr_out[IDX_MCAUSE]   = mcause_q;
    csr_out[IDX_MTVEC]    = mtvec_q;
    csr_out[IDX_MEPC]     = mepc_q;
  end

  assign mtvec_o   = mtvec_q;
  assign mepc_o    = mepc_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_csr_write_unit.sv
// tb/tb_csr_write_unit.sv - self-checking bench for csr_write_unit
module tb_csr_write_unit;

  localparam int N     = 64;
  localparam int W_CSR = 256;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    csr_we;
  logic [1:0]              csr_op;
  logic [11:0]             addr;
  logic [N-1:0]            wdata;
  logic                    trap_valid;
  logic [N-1:0]            trap_pc;
  logic [N-1:0]            trap_cause;
  logic                    mret_valid;
  logic [W_CSR-1:0][N-1:0] csr_out;
  logic [N-1:0]            mtvec_o;
  logic [N-1:0]            mepc_o;
  logic                    illegal_o;

  csr_write_unit #(.N(N), .W_CSR(W_CSR)) dut (
    .clk        (clk),
    .reset      (reset),
    .csr_we     (csr_we),
    .csr_op     (csr_op),
    .addr       (addr),
    .wdata      (wdata),
    .trap_valid (trap_valid),
    .trap_pc    (trap_pc),
    .trap_cause (trap_cause),
    .mret_valid (mret_valid),
    .csr_out    (csr_out),
    .mtvec_o    (mtvec_o),
    .mepc_o     (mepc_o),
    .illegal_o  (illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] scr;
    logic [63:0] st;
    logic [63:0] mc;
    logic [63:0] tv;
    logic [63:0] ep;
    logic [63:0] tvo;
    logic [63:0] epo;
    logic        ill;
    logic        others;
  } vec_t;

  vec_t sb[$];
  vec_t got, exp_v;
  int   n_vec = 0;
  int   n_bad = 0;

  // reference state
  logic [63:0] m_scr, m_st, m_mc, m_tv, m_ep;
  logic        m_ill;

  function automatic vec_t observed();
    vec_t v;
    v.scr    = csr_out[0];
    v.st     = csr_out[1];
    v.mc     = csr_out[2];
    v.tv     = csr_out[3];
    v.ep     = csr_out[4];
    v.tvo    = mtvec_o;
    v.epo    = mepc_o;
    v.ill    = illegal_o;
    v.others = |csr_out[W_CSR-1:5];
    return v;
  endfunction

  // Reference behaviour of one clock edge given the driven inputs.
  task automatic model_step(input logic rst, input logic we, input logic [1:0] op,
                            input logic [11:0] a, input logic [63:0] wd,
                            input logic trap, input logic [63:0] pc,
                            input logic [63:0] cause, input logic mret);
    logic [63:0] old, nv;
    logic        eff;
    if (!rst) begin
      m_scr = 0; m_st = 64'h1800; m_mc = 0; m_tv = 0; m_ep = 0; m_ill = 0;
    end else begin
      m_ill = 0;
      if (trap) begin
        m_ep = pc & ~64'd3;
        m_mc = cause;
        m_st = 64'h1800 | (m_st[3] ? 64'h80 : 64'h0);
      end else if (mret) begin
        m_st = 64'h1880 | (m_st[7] ? 64'h8 : 64'h0);
      end else if (we && op != 2'b00) begin
        case (a)
          12'h340: old = m_scr;
          12'h300: old = m_st;
          12'h342: old = m_mc;
          12'h305: old = m_tv;
          12'h341: old = m_ep;
          default: old = 0;
        endcase
        nv  = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
        eff = (op == 2'b01) || (wd != 0);
        if (eff) begin
          case (a)
            12'h340: m_scr = nv;
            12'h300: m_st  = 64'h1800 | (nv & 64'h88);
            12'h342: m_mc  = nv;
            12'h305: m_tv  = nv & ~64'd3;
            12'h341: m_ep  = nv & ~64'd3;
            default: m_ill = 1;
          endcase
        end
      end
    end
  endtask

  // Drive one cycle of stimulus, push the expected result, sample after the edge.
  task automatic drive(input logic rst, input logic we, input logic [1:0] op,
                       input logic [11:0] a, input logic [63:0] wd,
                       input logic trap, input logic [63:0] pc,
                       input logic [63:0] cause, input logic mret);
    vec_t e;
    reset = rst; csr_we = we; csr_op = op; addr = a; wdata = wd;
    trap_valid = trap; trap_pc = pc; trap_cause = cause; mret_valid = mret;
    model_step(rst, we, op, a, wd, trap, pc, cause, mret);
    e.scr = m_scr; e.st = m_st; e.mc = m_mc; e.tv = m_tv; e.ep = m_ep;
    e.tvo = m_tv; e.epo = m_ep; e.ill = m_ill; e.others = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic csr_acc(input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd);
    drive(1'b1, 1'b1, op, a, wd, 1'b0, 64'h0, 64'h0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 2'b00, 12'h0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL reset got=%h exp=%h", got, exp_v); end
    idle();
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL reset_idle got=%h exp=%h", got, exp_v); end
    n_vec++;
    if (csr_out[1] !== 64'h1800 || illegal_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_mstatus got=%h/%b exp=1800/0", csr_out[1], illegal_o);
    end
  endtask

  task automatic test_rmw();
    logic [63:0] wds [3] = '{64'hDEADBEEF, 64'hF, 64'hFF};
    logic [1:0]  ops [3] = '{2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      csr_acc(ops[i], 12'h340, wds[i]);
      got = observed(); exp_v = sb.pop_front(); n_vec++;
      if (got !== exp_v) begin n_bad++; $display("FAIL rmw_%0d got=%h exp=%h", i, got, exp_v); end
    end
    n_vec++;
    if (csr_out[0] !== 64'hDEADBE00) begin
      n_bad++; $display("FAIL rmw_final got=%h exp=deadbe00", csr_out[0]);
    end
  endtask

  task automatic test_fields();
    csr_acc(2'b01, 12'h305, 64'h80000003);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL mtvec got=%h exp=%h", got, exp_v); end
    n_vec++;
    if (mtvec_o !== 64'h80000000) begin n_bad++; $display("FAIL mtvec_o got=%h exp=80000000", mtvec_o); end
    csr_acc(2'b01, 12'h341, 64'h12345677);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL mepc got=%h exp=%h", got, exp_v); end
    csr_acc(2'b01, 12'h342, 64'hFFFF_0000_0000_0003);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL mcause got=%h exp=%h", got, exp_v); end
    csr_acc(2'b01, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL mstatus_rw got=%h exp=%h", got, exp_v); end
    n_vec++;
    if (csr_out[1] !== 64'h1888) begin n_bad++; $display("FAIL mstatus_1888 got=%h exp=1888", csr_out[1]); end
  endtask

  task automatic test_trap_mret();
    // trap with a concurrent mscratch write; the write must be dropped
    drive(1'b1, 1'b1, 2'b01, 12'h340, 64'h5, 1'b1, 64'h1006, 64'hB, 1'b0);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL trap got=%h exp=%h", got, exp_v); end
    n_vec++;
    if (mepc_o !== 64'h1004 || csr_out[2] !== 64'hB || csr_out[1] !== 64'h1880 || csr_out[0] !== 64'hDEADBE00) begin
      n_bad++; $display("FAIL trap_fields got=%h/%h/%h/%h exp=1004/b/1880/deadbe00", mepc_o, csr_out[2], csr_out[1], csr_out[0]);
    end
    drive(1'b1, 1'b0, 2'b00, 12'h0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b1);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL mret got=%h exp=%h", got, exp_v); end
    n_vec++;
    if (csr_out[1] !== 64'h1888) begin n_bad++; $display("FAIL mret_mstatus got=%h exp=1888", csr_out[1]); end
    // trap and mret together: trap wins; mret alone with illegal write drops it
    drive(1'b1, 1'b0, 2'b00, 12'h0, 64'h0, 1'b1, 64'h2003, 64'h7, 1'b1);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL trap_mret got=%h exp=%h", got, exp_v); end
    drive(1'b1, 1'b1, 2'b01, 12'h301, 64'h1, 1'b0, 64'h0, 64'h0, 1'b1);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL mret_drop got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_illegal();
    csr_acc(2'b01, 12'h301, 64'h1);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL misa_wr got=%h exp=%h", got, exp_v); end
    n_vec++;
    if (illegal_o !== 1'b1) begin n_bad++; $display("FAIL illegal_pulse got=%b exp=1", illegal_o); end
    idle();
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL illegal_clear got=%h exp=%h", got, exp_v); end
    csr_acc(2'b10, 12'hF14, 64'h0);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v || illegal_o !== 1'b0) begin n_bad++; $display("FAIL rs_zero got=%h exp=%h", got, exp_v); end
    csr_acc(2'b11, 12'hF11, 64'h4);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL rc_id got=%h exp=%h", got, exp_v); end
    csr_acc(2'b01, 12'h7C0, 64'h9);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL unmapped got=%h exp=%h", got, exp_v); end
    csr_acc(2'b00, 12'h340, 64'hAAAA);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL op_nop got=%h exp=%h", got, exp_v); end
    drive(1'b1, 1'b1, 2'b01, 12'h301, 64'h1, 1'b1, 64'h3000, 64'h2, 1'b0);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL trap_illegal got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] addrs [8] = '{12'h340, 12'h300, 12'h342, 12'h305, 12'h341, 12'h301, 12'hF12, 12'h7C0};
    logic [63:0] wd;
    for (int i = 0; i < 40; i++) begin
      wd = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
      drive(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), addrs[$urandom_range(0, 7)], wd,
            ($urandom_range(0, 9) == 0), {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 9) == 0));
      got = observed(); exp_v = sb.pop_front(); n_vec++;
      if (got !== exp_v) begin n_bad++; $display("FAIL b2b_%0d got=%h exp=%h", i, got, exp_v); end
    end
  endtask

  task automatic test_reset_trap();
    drive(1'b0, 1'b1, 2'b01, 12'h340, 64'h77, 1'b1, 64'h4444, 64'h3, 1'b1);
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL reset_trap got=%h exp=%h", got, exp_v); end
    n_vec++;
    if (csr_out[1] !== 64'h1800 || mepc_o !== 64'h0 || csr_out[2] !== 64'h0 || illegal_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_trap_vals got=%h/%h/%h/%b exp=1800/0/0/0", csr_out[1], mepc_o, csr_out[2], illegal_o);
    end
  endtask

  initial begin
    reset = 1'b0; csr_we = 1'b0; csr_op = 2'b00; addr = '0; wdata = '0;
    trap_valid = 1'b0; trap_pc = '0; trap_cause = '0; mret_valid = 1'b0;
    m_scr = 0; m_st = 0; m_mc = 0; m_tv = 0; m_ep = 0; m_ill = 0;
    @(negedge clk);
    test_reset();
    test_rmw();
    test_fields();
    test_trap_mret();
    test_illegal();
    test_back_to_back();
    test_reset_trap();
    idle();
    got = observed(); exp_v = sb.pop_front(); n_vec++;
    if (got !== exp_v) begin n_bad++; $display("FAIL final_idle got=%h exp=%h", got, exp_v); end
    n_vec++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_write_unit.md
Name: csr_write_unit

Overview:
- Write side of the machine-mode CSR path. Owns the read/write M-mode CSR storage and drives the `csr_out` array that `csr_dec` reads.
- Performs read-modify-write updates for CSRRW/CSRRS/CSRRC (and the immediate forms).
- Applies hardware-initiated updates: trap entry and MRET.
- Flags illegal CSR writes for the exception logic.

Parameters:
- N, 64, CSR data width.
- W_CSR, 256, number of entries in the `csr_out` array.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  reset, synchronous, active-low.
- csr_we  in  1  CSR instruction valid this cycle.
- csr_op  in  2  01=RW, 10=RS, 11=RC, 00=no-op.
- addr  in  12  CSR address.
- wdata  in  N  rs1 value, or the zimm zero-extended by the decode stage.
- trap_valid  in  1  trap entry request.
- trap_pc  in  N  PC of the faulting instruction.
- trap_cause  in  N  mcause value to record.
- mret_valid  in  1  MRET retiring.
- csr_out  out  N x W_CSR  storage array: [0]=mscratch, [1]=mstatus, [2]=mcause, [3]=mtvec, [4]=mepc; all other entries 0.
- mtvec_o  out  N  trap vector target (equals csr_out[3]).
- mepc_o  out  N  MRET return target (equals csr_out[4]).
- illegal_o  out  1  one-cycle pulse, registered: previous cycle's CSR write was illegal.

Behaviour:
- Reset (reset==0 at posedge):
  - All five registers are cleared, except mstatus = 0x1800 (MPP=2'b11).
  - illegal_o=0.
- Write latency: an update accepted at edge k is visible on csr_out after edge k. There is no forwarding; the pipeline handles hazards.
- Next-value computation from the current stored value `old`:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
- Write suppression: RS/RC with wdata==0 is a read-only access. Nothing is written and illegal_o is not raised.
- Field rules:
  - mstatus: only MIE (bit 3) and MPIE (bit 7) are writable. MPP[12:11] is fixed at 2'b11. All other bits read 0.
  - mtvec: bits[1:0] are forced to 00 (direct mode only).
  - mepc: bits[1:0] are forced to 00.
  - mscratch and mcause: full N-bit.
- Illegal writes: an effective write to 0x301, 0xF11–0xF14, or any unmapped address is illegal.
  - No state changes.
  - illegal_o=1 on the next cycle for one cycle.
- Trap entry (trap_valid=1):
  - mepc ← trap_pc & ~3.
  - mcause ← trap_cause.
  - mstatus.MPIE ← MIE.
  - mstatus.MIE ← 0.
- MRET (mret_valid=1, trap_valid=0):
  - mstatus.MIE ← MPIE.
  - mstatus.MPIE ← 1.
- Priority in the same cycle: trap > mret > CSR write.
  - A suppressed CSR write does not raise illegal_o.
  - A CSR write targeting an address the trap does not touch is still dropped; the trapping instruction does not retire.
- Reset takes priority over everything, including a trap in flight.
- csr_op=00 with csr_we=1 is a no-op.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams (MSCRATCH=0x340, MSTATUS=0x300, MCAUSE=0x342, MTVEC=0x305, MEPC=0x341, MISA=0x301, MVENDORID..MHARTID=0xF11..0xF14).
  - csr_out index constants 0..4.
  - csr_op enum.
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11) and MSTATUS_RESET.
- Sub-module csr_rmw: combinational. Inputs are old, wdata and csr_op; outputs are the next value and a write_effective flag.

Test Plan:
- Reset then idle:
  - csr_out[1]=0x1800.
  - csr_out[0,2,3,4]=0.
  - illegal_o=0.
- RW 0x340 with 0xDEADBEEF, then RS 0x340 with 0xF, then RC 0x340 with 0xFF:
  - csr_out[0]=0xDEADBEEF after the first edge.
  - csr_out[0]=0xDEADBEEF after the second edge.
  - csr_out[0]=0xDEADBE00 after the third edge.
- RW 0x305 with 0x80000003:
  - mtvec_o=0x80000000.
- RW 0x300 with 0xFFFF..FF:
  - csr_out[1]=0x1888.
- Then trap_valid with trap_pc=0x1006, cause=0xB, and a concurrent RW 0x340 with 0x5:
  - mepc=0x1004, mcause=0xB, mstatus=0x1880.
  - mscratch is unchanged.
- Then mret_valid:
  - mstatus=0x1888.
- RW 0x301 with 0x1:
  - illegal_o=1 for exactly one cycle.
  - No CSR changes.
- RS 0xF14 with 0:
  - illegal_o stays 0.
- Trap asserted on the same edge as reset=0:
  - All outputs take their reset values.
